// File: rtl/race_controller.sv
// race_controller: drag-racing game sequencer.
// Walks the game from the menu (IDLE) through the start-light countdown
// and the race to the result screen. It owns both car x-positions, the
// start-light state, the car speeds and the race timer. All outputs are
// registered; the state encoding is visible on the state output.
//
// Input events are single-cycle pulses (no handshake): each pulse is acted
// on in the cycle it is seen and the effect is visible on the outputs one
// cycle later.
module race_controller #(
    parameter int LIGHT_MS    = 1000,
    parameter int NUM_LIGHTS  = 3,
    parameter int START_X     = 256,
    parameter int FINISH_X    = 1000,
    parameter int SPEED_MAX   = 15,
    parameter int DRAG_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_ms,
    input  logic        frame_tick,
    input  logic        start_game,
    input  logic        back_to_menu,
    input  logic        p1_throttle,
    input  logic        p2_throttle,
    output logic [1:0]  state,
    output logic [1:0]  lights,
    output logic        go,
    output logic [10:0] xpos_p1,
    output logic [10:0] xpos_p2,
    output logic [1:0]  winner,
    output logic [1:0]  false_start,
    output logic [15:0] race_ms
);

    localparam int MS_W   = $clog2(LIGHT_MS + 1);
    localparam int SPD_W  = $clog2(SPEED_MAX + 1);
    localparam int DRAG_W = $clog2(DRAG_FRAMES + 1);

    localparam logic [10:0]       START_XL  = 11'(START_X);
    localparam logic [10:0]       FINISH_XL = 11'(FINISH_X);
    localparam logic [SPD_W-1:0]  SPD_MAX_L = SPD_W'(SPEED_MAX);
    localparam logic [1:0]        NUM_L     = 2'(NUM_LIGHTS);
    localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(LIGHT_MS - 1);
    localparam logic [DRAG_W-1:0] DRAG_LAST = DRAG_W'(DRAG_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_RACE      = 2'd2,
        S_FINISH    = 2'd3
    } state_t;

    // Registered state
    state_t            state_q;
    logic [1:0]        lights_q;
    logic              go_q;
    logic [10:0]       x1_q;
    logic [10:0]       x2_q;
    logic [1:0]        winner_q;
    logic [1:0]        fs_q;
    logic [15:0]       race_ms_q;
    logic [MS_W-1:0]   ms_q;
    logic [SPD_W-1:0]  spd1_q;
    logic [SPD_W-1:0]  spd2_q;
    logic [DRAG_W-1:0] drag_q;
    logic              chk_q;    // a position update happened last cycle

    // Next-state values
    state_t            state_d;
    logic [1:0]        lights_d;
    logic              go_d;
    logic [10:0]       x1_d;
    logic [10:0]       x2_d;
    logic [1:0]        winner_d;
    logic [1:0]        fs_d;
    logic [15:0]       race_ms_d;
    logic [MS_W-1:0]   ms_d;
    logic [SPD_W-1:0]  spd1_d;
    logic [SPD_W-1:0]  spd2_d;
    logic [DRAG_W-1:0] drag_d;
    logic              chk_d;

    logic              do_clear;   // return every register to its menu value
    logic              drag_dec;   // this frame_tick is a drag frame
    logic              hit1;
    logic              hit2;

    // Speed step: +1 on throttle, -1 on drag, both together cancel.
    function automatic logic [SPD_W-1:0] next_speed(
        input logic [SPD_W-1:0] s,
        input logic             inc,
        input logic             dec
    );
        logic [SPD_W-1:0] r;
        r = s;
        if (inc && !dec) begin
            if (s != SPD_MAX_L) r = s + SPD_W'(1);
        end else if (dec && !inc) begin
            if (s != '0) r = s - SPD_W'(1);
        end
        return r;
    endfunction

    // Position step: add in 12 bits so the sum cannot wrap, then clamp.
    function automatic logic [10:0] next_pos(
        input logic [10:0]      x,
        input logic [SPD_W-1:0] s
    );
        logic [11:0] sum;
        logic [10:0] r;
        sum = {1'b0, x} + 12'(s);
        if (sum >= {1'b0, FINISH_XL}) r = FINISH_XL;
        else                          r = sum[10:0];
        return r;
    endfunction

    assign hit1 = (x1_q == FINISH_XL);
    assign hit2 = (x2_q == FINISH_XL);

    // Next-state and next-output logic for the game sequencer
    always_comb begin
        state_d   = state_q;
        lights_d  = lights_q;
        go_d      = go_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        winner_d  = winner_q;
        fs_d      = fs_q;
        race_ms_d = race_ms_q;
        ms_d      = ms_q;
        spd1_d    = spd1_q;
        spd2_d    = spd2_q;
        drag_d    = drag_q;
        chk_d     = 1'b0;
        do_clear  = 1'b0;
        drag_dec  = 1'b0;

        if (back_to_menu) begin
            // Menu return beats every other event in the same cycle.
            do_clear = 1'b1;
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Everything is already at menu values here.
                    if (start_game) state_d = S_COUNTDOWN;
                end

                S_COUNTDOWN: begin
                    if (p1_throttle || p2_throttle) begin
                        // Jumping the lights ends the game; a double jump has no winner.
                        fs_d     = {p2_throttle, p1_throttle};
                        winner_d = {p1_throttle && !p2_throttle,
                                    p2_throttle && !p1_throttle};
                        state_d  = S_FINISH;
                    end else if (tick_ms) begin
                        if (ms_q == MS_LAST) begin
                            ms_d = '0;
                            if (lights_q == NUM_L) begin
                                lights_d = 2'd0;
                                go_d     = 1'b1;
                                state_d  = S_RACE;
                            end else begin
                                lights_d = lights_q + 2'd1;
                            end
                        end else begin
                            ms_d = ms_q + MS_W'(1);
                        end
                    end
                end

                S_RACE: begin
                    if (chk_q && (hit1 || hit2)) begin
                        // winner bit0 = P1 finished, bit1 = P2 finished.
                        winner_d = {hit2, hit1};
                        go_d     = 1'b0;
                        state_d  = S_FINISH;
                    end else begin
                        chk_d = frame_tick;
                        if (tick_ms && (race_ms_q != 16'hFFFF))
                            race_ms_d = race_ms_q + 16'd1;
                        if (frame_tick) begin
                            // Positions use the speed held before this cycle's changes.
                            x1_d = next_pos(x1_q, spd1_q);
                            x2_d = next_pos(x2_q, spd2_q);
                            if (drag_q == DRAG_LAST) begin
                                drag_d   = '0;
                                drag_dec = 1'b1;
                            end else begin
                                drag_d = drag_q + DRAG_W'(1);
                            end
                        end
                        spd1_d = next_speed(spd1_q, p1_throttle, drag_dec);
                        spd2_d = next_speed(spd2_q, p2_throttle, drag_dec);
                    end
                end

                S_FINISH: begin
                    // Result is frozen; only a new game (or menu) moves on.
                    if (start_game) begin
                        do_clear = 1'b1;
                        state_d  = S_COUNTDOWN;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end

        if (do_clear) begin
            lights_d  = 2'd0;
            go_d      = 1'b0;
            x1_d      = START_XL;
            x2_d      = START_XL;
            winner_d  = 2'd0;
            fs_d      = 2'd0;
            race_ms_d = 16'd0;
            ms_d      = '0;
            spd1_d    = '0;
            spd2_d    = '0;
            drag_d    = '0;
            chk_d     = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lights_q  <= 2'd0;
            go_q      <= 1'b0;
            x1_q      <= START_XL;
            x2_q      <= START_XL;
            winner_q  <= 2'd0;
            fs_q      <= 2'd0;
            race_ms_q <= 16'd0;
            ms_q      <= '0;
            spd1_q    <= '0;
            spd2_q    <= '0;
            drag_q    <= '0;
            chk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lights_q  <= lights_d;
            go_q      <= go_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            winner_q  <= winner_d;
            fs_q      <= fs_d;
            race_ms_q <= race_ms_d;
            ms_q      <= ms_d;
            spd1_q    <= spd1_d;
            spd2_q    <= spd2_d;
            drag_q    <= drag_d;
            chk_q     <= chk_d;
        end
    end

    assign state       = state_q;
    assign lights      = lights_q;
    assign go          = go_q;
    assign xpos_p1     = x1_q;
    assign xpos_p2     = x2_q;
    assign winner      = winner_q;
    assign false_start = fs_q;
    assign race_ms     = race_ms_q;

endmodule

// File: tb/tb_race_controller.sv
// tb_race_controller: table-driven and sequence checks for race_controller.
module tb_race_controller;

    localparam int START_X     = 256;
    localparam int FINISH_X    = 1000;
    localparam int SPEED_MAX   = 15;
    localparam int DRAG_FRAMES = 8;

    // stimulus bits: {start_game, back_to_menu, p1, p2, tick_ms, frame_tick}
    localparam logic [5:0] I_NONE  = 6'b000000;
    localparam logic [5:0] I_START = 6'b100000;
    localparam logic [5:0] I_BACK  = 6'b010000;
    localparam logic [5:0] I_P1    = 6'b001000;
    localparam logic [5:0] I_P2    = 6'b000100;
    localparam logic [5:0] I_TICK  = 6'b000010;
    localparam logic [5:0] I_FRAME = 6'b000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_ms, frame_tick, start_game, back_to_menu;
    logic        p1_throttle, p2_throttle;
    logic [1:0]  state, lights, winner, false_start;
    logic        go;
    logic [10:0] xpos_p1, xpos_p2;
    logic [15:0] race_ms;

    race_controller dut (
        .clk          (clk),
        .rst          (rst),
        .tick_ms      (tick_ms),
        .frame_tick   (frame_tick),
        .start_game   (start_game),
        .back_to_menu (back_to_menu),
        .p1_throttle  (p1_throttle),
        .p2_throttle  (p2_throttle),
        .state        (state),
        .lights       (lights),
        .go           (go),
        .xpos_p1      (xpos_p1),
        .xpos_p2      (xpos_p2),
        .winner       (winner),
        .false_start  (false_start),
        .race_ms      (race_ms)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        int          pre;    // unchecked tick_ms cycles before the vector
        logic [5:0]  stim;
        logic [46:0] exp;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    logic [46:0] exp_q[$];
    string       name_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          m_x, m_spd, rt;
    bit          done;
    logic [5:0]  stim_v;
    logic [46:0] rst_v;

    function automatic logic [46:0] mk(input logic [1:0] st, input logic [1:0] lt,
                                       input logic g, input int x1, input int x2,
                                       input logic [1:0] w, input logic [1:0] fs,
                                       input int rms);
        return {st, lt, g, 11'(x1), 11'(x2), w, fs, 16'(rms)};
    endfunction

    function automatic vec_t mkv(input int pre, input logic [5:0] stim,
                                 input logic [46:0] exp, input string name);
        vec_t v;
        v.pre = pre; v.stim = stim; v.exp = exp; v.name = name;
        return v;
    endfunction

    // Reference speed/position rules for the race sequences
    function automatic int spd_next(input int s, input bit inc, input bit dec);
        if (inc && !dec) return (s < SPEED_MAX) ? s + 1 : s;
        if (dec && !inc) return (s > 0) ? s - 1 : s;
        return s;
    endfunction

    function automatic int pos_next(input int x, input int s);
        return (x + s >= FINISH_X) ? FINISH_X : x + s;
    endfunction

    // driver: one cycle of input pulses, inputs changed on the falling edge
    task automatic drive(input logic [5:0] stim);
        @(negedge clk);
        {start_game, back_to_menu, p1_throttle, p2_throttle, tick_ms, frame_tick} = stim;
        @(posedge clk);
        #1;
        {start_game, back_to_menu, p1_throttle, p2_throttle, tick_ms, frame_tick} = 6'b0;
    endtask

    // scoreboard: pop the oldest expectation and compare against the outputs
    task automatic check_front();
        logic [46:0] e, a;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {state, lights, go, xpos_p1, xpos_p2, winner, false_start, race_ms};
        total_cnt++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s: got st=%0d lt=%0d go=%0d x1=%0d x2=%0d win=%0d fs=%0d ms=%0d, want st=%0d lt=%0d go=%0d x1=%0d x2=%0d win=%0d fs=%0d ms=%0d",
                      nm, a[46:45], a[44:43], a[42], a[41:31], a[30:20], a[19:18], a[17:16], a[15:0],
                      e[46:45], e[44:43], e[42], e[41:31], e[30:20], e[19:18], e[17:16], e[15:0]);
    endtask

    task automatic step(input logic [5:0] stim, input logic [46:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        drive(stim);
        check_front();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) drive(I_TICK);
    endtask

    task automatic to_race();
        step(I_START, mk(1, 0, 0, START_X, START_X, 0, 0, 0), "race_start_cd");
        run_ticks(4 * 1000 - 1);
        step(I_TICK, mk(2, 0, 1, START_X, START_X, 0, 0, 0), "race_go");
    endtask

    initial begin
        // reset
        rst = 1'b1;
        {start_game, back_to_menu, p1_throttle, p2_throttle, tick_ms, frame_tick} = 6'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rst_v = mk(0, 0, 0, START_X, START_X, 0, 0, 0);
        exp_q.push_back(rst_v);
        name_q.push_back("reset_values");
        check_front();

        // countdown, first race cycles and menu return
        tbl.push_back(mkv(0,   I_P1,    rst_v,                         "idle_throttle_ignored"));
        tbl.push_back(mkv(0,   I_START, mk(1, 0, 0, 256, 256, 0, 0, 0), "start_to_countdown"));
        tbl.push_back(mkv(998, I_TICK,  mk(1, 0, 0, 256, 256, 0, 0, 0), "ms999_no_light"));
        tbl.push_back(mkv(0,   I_TICK,  mk(1, 1, 0, 256, 256, 0, 0, 0), "ms1000_light1"));
        tbl.push_back(mkv(999, I_TICK,  mk(1, 2, 0, 256, 256, 0, 0, 0), "ms2000_light2"));
        tbl.push_back(mkv(999, I_TICK,  mk(1, 3, 0, 256, 256, 0, 0, 0), "ms3000_light3"));
        tbl.push_back(mkv(998, I_TICK,  mk(1, 3, 0, 256, 256, 0, 0, 0), "ms3999_hold"));
        tbl.push_back(mkv(0,   I_TICK,  mk(2, 0, 1, 256, 256, 0, 0, 0), "ms4000_go"));
        tbl.push_back(mkv(0,   I_TICK,  mk(2, 0, 1, 256, 256, 0, 0, 1), "race_ms_first"));
        tbl.push_back(mkv(0,   I_P1,    mk(2, 0, 1, 256, 256, 0, 0, 1), "p1_press"));
        tbl.push_back(mkv(0,   I_FRAME, mk(2, 0, 1, 257, 256, 0, 0, 1), "frame_move1"));
        tbl.push_back(mkv(0,   I_FRAME, mk(2, 0, 1, 258, 256, 0, 0, 1), "frame_move2"));
        tbl.push_back(mkv(0,   I_P2 | I_TICK, mk(2, 0, 1, 258, 256, 0, 0, 2), "p2_press_tick"));
        tbl.push_back(mkv(0,   I_BACK | I_FRAME | I_P2 | I_TICK, rst_v, "back_mid_race"));
        tbl.push_back(mkv(0,   I_NONE,  rst_v,                         "idle_after_back"));
        tbl.push_back(mkv(0,   I_TICK | I_FRAME | I_P1 | I_P2, rst_v,  "idle_ignores_all"));
        for (int i = 0; i < tbl.size(); i++) begin
            run_ticks(tbl[i].pre);
            step(tbl[i].stim, tbl[i].exp, tbl[i].name);
        end

        // P1 false start at ms 1500
        step(I_START, mk(1, 0, 0, 256, 256, 0, 0, 0), "fs1_start");
        run_ticks(1499);
        step(I_P1, mk(3, 1, 0, 256, 256, 2, 1, 0), "fs1_finish");
        step(I_P2 | I_TICK | I_FRAME, mk(3, 1, 0, 256, 256, 2, 1, 0), "fs1_frozen");
        step(I_BACK, rst_v, "fs1_back");

        // both players jump together
        step(I_START, mk(1, 0, 0, 256, 256, 0, 0, 0), "fs2_start");
        run_ticks(10);
        step(I_P1 | I_P2, mk(3, 0, 0, 256, 256, 0, 3, 0), "fs_both");
        step(I_BACK, rst_v, "fs2_back");

        // P1 alone: 16 presses (speed saturates at 15), then frames to the line
        to_race();
        for (int i = 0; i < 16; i++)
            step(I_P1, mk(2, 0, 1, START_X, START_X, 0, 0, 0), "p1_solo_press");
        m_x = START_X; m_spd = 15; done = 1'b0;
        for (int f = 1; f <= 300 && !done; f++) begin
            m_x   = pos_next(m_x, m_spd);
            m_spd = spd_next(m_spd, 1'b0, (f % DRAG_FRAMES) == 0);
            step(I_FRAME, mk(2, 0, 1, m_x, START_X, 0, 0, 0), "p1_solo_pos");
            if (m_x == FINISH_X) begin
                step(I_NONE, mk(3, 0, 0, FINISH_X, START_X, 1, 0, 0), "p1_solo_finish");
                done = 1'b1;
            end else begin
                step(I_NONE, mk(2, 0, 1, m_x, START_X, 0, 0, 0), "p1_solo_running");
            end
        end
        if (!done) begin
            total_cnt++;
            $display("FAIL p1_solo_timeout: got no finish in 300 frames, want finish");
        end
        step(I_P1 | I_FRAME | I_TICK, mk(3, 0, 0, FINISH_X, START_X, 1, 0, 0), "p1_solo_frozen");
        step(I_BACK, rst_v, "p1_solo_back");

        // equal press sequences: tie, race_ms counts ticks since go
        to_race();
        rt = 0;
        rt++;
        step(I_START | I_TICK, mk(2, 0, 1, START_X, START_X, 0, 0, rt), "tie_start_ignored");
        for (int i = 0; i < 10; i++) begin
            rt++;
            step(I_P1 | I_P2 | I_TICK, mk(2, 0, 1, START_X, START_X, 0, 0, rt), "tie_press");
        end
        m_x = START_X; m_spd = 10; done = 1'b0;
        for (int n = 1; n <= 300 && !done; n++) begin
            // presses on even frames, so every drag frame also carries a press
            m_x   = pos_next(m_x, m_spd);
            m_spd = spd_next(m_spd, (n % 2) == 0, (n % DRAG_FRAMES) == 0);
            rt++;
            stim_v = I_FRAME | I_TICK | (((n % 2) == 0) ? (I_P1 | I_P2) : I_NONE);
            step(stim_v, mk(2, 0, 1, m_x, m_x, 0, 0, rt), "tie_pos");
            if (m_x == FINISH_X) begin
                step(I_NONE, mk(3, 0, 0, FINISH_X, FINISH_X, 3, 0, rt), "tie_finish");
                done = 1'b1;
            end else begin
                step(I_NONE, mk(2, 0, 1, m_x, m_x, 0, 0, rt), "tie_running");
            end
        end
        if (!done) begin
            total_cnt++;
            $display("FAIL tie_timeout: got no finish in 300 frames, want finish");
        end
        step(I_TICK, mk(3, 0, 0, FINISH_X, FINISH_X, 3, 0, rt), "tie_time_frozen");
        step(I_BACK, rst_v, "tie_back");

        // report
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
